ctrl_fsm: RTL and testbench

Multicycle control unit for the EEL RV32I core. Sequences fetch, decode, execute and memory phases, and drives every datapath select, including IMM_SEL into the immediate extender. It also provides the register-file, PC, IR and memory strobes. It sits between the instruction register and the datapath muxes, and handshakes with the unified memory port via MEM_ACK.

---
 rtl/ctrl_fsm_pkg.sv | 59 +++++
 rtl/ctrl_fsm_if.sv | 33 +++
 rtl/ctrl_fsm_decode.sv | 77 +++++++
 rtl/ctrl_fsm.sv | 142 ++++++++++++++
 tb/tb_ctrl_fsm.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_fsm_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// The IMM_SEL encoding here is also consumed by the immediate extender.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_TRAP    = 3'd4
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_JALR   = 2'b01;
    localparam logic [1:0] PC_TARGET = 2'b10;
    localparam logic [1:0] PC_TRAP   = 2'b11;

    localparam logic [1:0] RF_ALU = 2'b00;
    localparam logic [1:0] RF_MEM = 2'b01;
    localparam logic [1:0] RF_PC4 = 2'b10;
    localparam logic [1:0] RF_IMM = 2'b11;

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic [3:0] alu_fun;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic [1:0] rf_sel;
        logic [1:0] pc_sel;
        logic       rf_wb;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/ctrl_fsm_if.sv
// Control-unit bundle: instruction/ack/branch inputs and every datapath select.
// MEM_RE/MEM_WE act as valid and MEM_ACK as ready; a request stays asserted, unchanged, until the cycle MEM_ACK is high, which completes it.
interface ctrl_fsm_if;
    logic [31:0] IR;
    logic        MEM_ACK;
    logic        BR_TAKEN;
    logic        IR_WE;
    logic        PC_WE;
    logic [1:0]  PC_SEL;
    logic [2:0]  IMM_SEL;
    logic        ALU_SRCA;
    logic [1:0]  ALU_SRCB;
    logic [3:0]  ALU_FUN;
    logic        RF_WE;
    logic [1:0]  RF_SEL;
    logic        MEM_RE;
    logic        MEM_WE;
    logic [1:0]  MEM_SIZE;
    logic        TRAP;
    logic [2:0]  STATE;

    modport master (
        input  IR, MEM_ACK, BR_TAKEN,
        output IR_WE, PC_WE, PC_SEL, IMM_SEL, ALU_SRCA, ALU_SRCB, ALU_FUN,
               RF_WE, RF_SEL, MEM_RE, MEM_WE, MEM_SIZE, TRAP, STATE
    );

    modport slave (
        output IR, MEM_ACK, BR_TAKEN,
        input  IR_WE, PC_WE, PC_SEL, IMM_SEL, ALU_SRCA, ALU_SRCB, ALU_FUN,
               RF_WE, RF_SEL, MEM_RE, MEM_WE, MEM_SIZE, TRAP, STATE
    );
endinterface

// File: rtl/ctrl_fsm_decode.sv
// Combinational instruction decode: IR -> datapath selects and instruction class.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_ir_bits;

    assign opcode         = ir[6:0];
    assign funct3         = ir[14:12];
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    always_comb begin
        dec = '0;
        case (opcode)
            OPC_OP: begin
                dec.alu_fun = {ir[30], funct3};
                dec.rf_sel  = RF_ALU;
                dec.rf_wb   = 1'b1;
            end
            OPC_OP_IMM: begin
                // ir[30] belongs to the immediate except for the shift-right pair
                dec.imm_sel  = IMM_I;
                dec.alu_srcb = SRCB_IMM;
                dec.alu_fun  = {(funct3 == 3'b101) ? ir[30] : 1'b0, funct3};
                dec.rf_sel   = RF_ALU;
                dec.rf_wb    = 1'b1;
            end
            OPC_LUI: begin
                dec.imm_sel = IMM_U;
                dec.rf_sel  = RF_IMM;
                dec.rf_wb   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm_sel  = IMM_U;
                dec.alu_srca = 1'b1;
                dec.alu_srcb = SRCB_IMM;
                dec.rf_sel   = RF_ALU;
                dec.rf_wb    = 1'b1;
            end
            OPC_JAL: begin
                dec.imm_sel = IMM_J;
                dec.pc_sel  = PC_TARGET;
                dec.rf_sel  = RF_PC4;
                dec.rf_wb   = 1'b1;
            end
            OPC_JALR: begin
                dec.imm_sel = IMM_I;
                dec.pc_sel  = PC_JALR;
                dec.rf_sel  = RF_PC4;
                dec.rf_wb   = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm_sel   = IMM_B;
                dec.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                dec.imm_sel  = IMM_I;
                dec.alu_srcb = SRCB_IMM;
                dec.rf_sel   = RF_MEM;
                dec.is_load  = 1'b1;
            end
            OPC_STORE: begin
                dec.imm_sel  = IMM_S;
                dec.alu_srcb = SRCB_IMM;
                dec.is_store = 1'b1;
            end
            OPC_FENCE: ;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM(/TRAP) sequencing and strobes.
// Define CTRL_TRAP_EN for illegal-opcode and memory-timeout traps.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    ctrl_fsm_if.master bus
);

    state_t state;
    dec_t   dec;
    logic   is_mem;

    ctrl_decode u_decode (
        .ir  (bus.IR),
        .dec (dec)
    );

    assign is_mem = dec.is_load | dec.is_store;

`ifdef CTRL_TRAP_EN
    logic [3:0] wait_cnt;
    logic       timeout;

    // Counter holds the number of ack-less cycles already spent in this FETCH/MEM visit
    assign timeout = (wait_cnt == 4'(MEM_TIMEOUT - 1)) && !bus.MEM_ACK;
`else
    localparam int unused_timeout = MEM_TIMEOUT;
    logic          unused_illegal;
    assign unused_illegal = dec.illegal;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_FETCH;
`ifdef CTRL_TRAP_EN
            wait_cnt <= 4'd0;
`endif
        end else begin
`ifdef CTRL_TRAP_EN
            if ((state == ST_FETCH || state == ST_MEM) && !bus.MEM_ACK)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;
`endif
            case (state)
                ST_FETCH: begin
                    if (bus.MEM_ACK) state <= ST_DECODE;
`ifdef CTRL_TRAP_EN
                    else if (timeout) state <= ST_TRAP;
`endif
                end
                ST_DECODE: state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (is_mem) state <= ST_MEM;
`ifdef CTRL_TRAP_EN
                    else if (dec.illegal) state <= ST_TRAP;
`endif
                    else state <= ST_FETCH;
                end
                ST_MEM: begin
                    if (bus.MEM_ACK) state <= ST_FETCH;
`ifdef CTRL_TRAP_EN
                    else if (timeout) state <= ST_TRAP;
`endif
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.IR_WE    = 1'b0;
        bus.PC_WE    = 1'b0;
        bus.PC_SEL   = PC_PLUS4;
        bus.IMM_SEL  = 3'b000;
        bus.ALU_SRCA = 1'b0;
        bus.ALU_SRCB = 2'b00;
        bus.ALU_FUN  = 4'b0000;
        bus.RF_WE    = 1'b0;
        bus.RF_SEL   = 2'b00;
        bus.MEM_RE   = 1'b0;
        bus.MEM_WE   = 1'b0;
        bus.MEM_SIZE = 2'b00;
        bus.TRAP     = 1'b0;
        bus.STATE    = 3'd0;
        if (!RST) begin
            bus.STATE = state;
            if (state == ST_DECODE || state == ST_EXECUTE || state == ST_MEM) begin
                bus.IMM_SEL  = dec.imm_sel;
                bus.ALU_SRCA = dec.alu_srca;
                bus.ALU_SRCB = dec.alu_srcb;
                bus.ALU_FUN  = dec.alu_fun;
            end
            case (state)
                ST_FETCH: begin
                    bus.MEM_RE   = 1'b1;
                    bus.MEM_SIZE = SIZE_WORD;
                    bus.IR_WE    = bus.MEM_ACK;
                end
                ST_EXECUTE: begin
                    // Loads/stores only form the address here; an illegal opcode without traps is a NOP
`ifdef CTRL_TRAP_EN
                    if (!is_mem && !dec.illegal) begin
`else
                    if (!is_mem) begin
`endif
                        bus.PC_WE  = 1'b1;
                        bus.RF_WE  = dec.rf_wb;
                        bus.RF_SEL = dec.rf_sel;
                        if (dec.is_branch)
                            bus.PC_SEL = bus.BR_TAKEN ? PC_TARGET : PC_PLUS4;
                        else
                            bus.PC_SEL = dec.pc_sel;
                    end
                end
                ST_MEM: begin
                    bus.MEM_RE   = dec.is_load;
                    bus.MEM_WE   = dec.is_store;
                    bus.MEM_SIZE = bus.IR[13:12];
                    if (bus.MEM_ACK) begin
                        bus.PC_WE  = 1'b1;
                        bus.RF_WE  = dec.is_load;
                        bus.RF_SEL = dec.is_load ? RF_MEM : RF_ALU;
                    end
                end
`ifdef CTRL_TRAP_EN
                ST_TRAP: begin
                    bus.TRAP   = 1'b1;
                    bus.PC_WE  = 1'b1;
                    bus.PC_SEL = PC_TRAP;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed, table-driven bench for ctrl_fsm; trap sequences are built with CTRL_TRAP_EN.
module tb_ctrl_fsm;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_fsm_if bus ();

    ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        br;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic [2:0]  imm;
        logic        srca;
        logic [1:0]  srcb;
        logic [3:0]  fun;
        logic        rf_we;
        logic [1:0]  rf_sel;
        logic        is_ld;
        logic        is_st;
    } vec_t;

    vec_t vecs[$];

    // {IR_WE, PC_WE, PC_SEL, IMM_SEL, SRCA, SRCB, FUN, RF_WE, RF_SEL, RE, WE, SIZE, TRAP, STATE}
    function automatic logic [24:0] pk(input logic ir_we, input logic pc_we, input logic [1:0] pc_sel,
                                       input logic [2:0] imm, input logic srca, input logic [1:0] srcb,
                                       input logic [3:0] fun, input logic rf_we, input logic [1:0] rf_sel,
                                       input logic re, input logic we, input logic [1:0] size,
                                       input logic trap, input logic [2:0] st);
        return {ir_we, pc_we, pc_sel, imm, srca, srcb, fun, rf_we, rf_sel, re, we, size, trap, st};
    endfunction

    function automatic logic [24:0] snap();
        return {bus.IR_WE, bus.PC_WE, bus.PC_SEL, bus.IMM_SEL, bus.ALU_SRCA, bus.ALU_SRCB, bus.ALU_FUN,
                bus.RF_WE, bus.RF_SEL, bus.MEM_RE, bus.MEM_WE, bus.MEM_SIZE, bus.TRAP, bus.STATE};
    endfunction

    task automatic check(input string name, input logic [24:0] exp);
        logic [24:0] act;
        act = snap();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %07h expected %07h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [24:0] fetch_idle;
    logic [24:0] fetch_ack;

    // Runs one instruction with zero-wait memory, starting and ending in FETCH.
    task automatic run_row(input vec_t v);
        logic [1:0] mem_rf_sel;
        mem_rf_sel = v.is_ld ? 2'b01 : 2'b00;
        bus.MEM_ACK = 1'b1;
        #1 check({v.name, " fetch"}, fetch_ack);
        tick();
        bus.MEM_ACK  = 1'b0;
        bus.IR       = v.ir;
        bus.BR_TAKEN = v.br;
        #1 check({v.name, " decode"}, pk(0, 0, 2'b00, v.imm, v.srca, v.srcb, v.fun, 0, 2'b00, 0, 0, 2'b00, 0, 3'd1));
        tick();
        #1 check({v.name, " execute"}, pk(0, v.pc_we, v.pc_sel, v.imm, v.srca, v.srcb, v.fun,
                                          v.rf_we, v.rf_sel, 0, 0, 2'b00, 0, 3'd2));
        tick();
        if (v.is_ld || v.is_st) begin
            bus.MEM_ACK = 1'b1;
            #1 check({v.name, " mem"}, pk(0, 1, 2'b00, v.imm, v.srca, v.srcb, v.fun, v.is_ld, mem_rf_sel,
                                          v.is_ld, v.is_st, v.ir[13:12], 0, 3'd3));
            tick();
            bus.MEM_ACK = 1'b0;
        end
        #1 check({v.name, " back to fetch"}, fetch_idle);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int re_cycles;
        fetch_idle = pk(0, 0, 2'b00, 3'd0, 0, 2'b00, 4'd0, 0, 2'b00, 1, 0, 2'b10, 0, 3'd0);
        fetch_ack  = pk(1, 0, 2'b00, 3'd0, 0, 2'b00, 4'd0, 0, 2'b00, 1, 0, 2'b10, 0, 3'd0);

        //            name        ir            br pcwe pcsel  imm   a  srcb   fun    rfwe rfsel ld st
        vecs.push_back('{"add",   32'h00A50533, 0, 1, 2'b00, 3'd0, 0, 2'b00, 4'h0, 1, 2'b00, 0, 0});
        vecs.push_back('{"sub",   32'h40A50533, 0, 1, 2'b00, 3'd0, 0, 2'b00, 4'h8, 1, 2'b00, 0, 0});
        vecs.push_back('{"srai",  32'h40005013, 0, 1, 2'b00, 3'd0, 0, 2'b01, 4'hD, 1, 2'b00, 0, 0});
        vecs.push_back('{"addi",  32'h40000013, 0, 1, 2'b00, 3'd0, 0, 2'b01, 4'h0, 1, 2'b00, 0, 0});
        vecs.push_back('{"lui",   32'h12345037, 0, 1, 2'b00, 3'd3, 0, 2'b00, 4'h0, 1, 2'b11, 0, 0});
        vecs.push_back('{"auipc", 32'h00000017, 0, 1, 2'b00, 3'd3, 1, 2'b01, 4'h0, 1, 2'b00, 0, 0});
        vecs.push_back('{"jal",   32'hDEADBEEF, 0, 1, 2'b10, 3'd4, 0, 2'b00, 4'h0, 1, 2'b10, 0, 0});
        vecs.push_back('{"jalr",  32'h000500E7, 0, 1, 2'b01, 3'd0, 0, 2'b00, 4'h0, 1, 2'b10, 0, 0});
        vecs.push_back('{"beq_t", 32'h00000063, 1, 1, 2'b10, 3'd2, 0, 2'b00, 4'h0, 0, 2'b00, 0, 0});
        vecs.push_back('{"beq_n", 32'h00000063, 0, 1, 2'b00, 3'd2, 0, 2'b00, 4'h0, 0, 2'b00, 0, 0});
        vecs.push_back('{"fence", 32'h0000000F, 0, 1, 2'b00, 3'd0, 0, 2'b00, 4'h0, 0, 2'b00, 0, 0});
        vecs.push_back('{"lw",    32'h00052283, 0, 0, 2'b00, 3'd0, 0, 2'b01, 4'h0, 0, 2'b00, 1, 0});
        vecs.push_back('{"lb",    32'h00050283, 0, 0, 2'b00, 3'd0, 0, 2'b01, 4'h0, 0, 2'b00, 1, 0});
        vecs.push_back('{"sw",    32'h00A52023, 0, 0, 2'b00, 3'd1, 0, 2'b01, 4'h0, 0, 2'b00, 0, 1});
`ifndef CTRL_TRAP_EN
        vecs.push_back('{"illegal_nop", 32'hFFFFFFFF, 0, 1, 2'b00, 3'd0, 0, 2'b00, 4'h0, 0, 2'b00, 0, 0});
`endif

        // Reset held two cycles with live inputs: every output must be 0
        rst          = 1'b1;
        bus.IR       = 32'h00A50533;
        bus.MEM_ACK  = 1'b1;
        bus.BR_TAKEN = 1'b1;
        tick();
        tick();
        check("reset outputs", 25'd0);
        rst          = 1'b0;
        bus.MEM_ACK  = 1'b0;
        bus.BR_TAKEN = 1'b0;
        #1 check("after reset", fetch_idle);

        foreach (vecs[i]) run_row(vecs[i]);

        // Fetch waits: no IR_WE and no progress until MEM_ACK
        for (int i = 0; i < 3; i++) begin
            #1 check("fetch wait", fetch_idle);
            tick();
        end

        // lw with three wait cycles in MEM
        re_cycles   = 0;
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        bus.IR      = 32'h00052283;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            #1 check("lw mem wait", pk(0, 0, 2'b00, 3'd0, 0, 2'b01, 4'h0, 0, 2'b00, 1, 0, 2'b10, 0, 3'd3));
            re_cycles += int'(bus.MEM_RE);
            tick();
        end
        bus.MEM_ACK = 1'b1;
        #1 check("lw mem ack", pk(0, 1, 2'b00, 3'd0, 0, 2'b01, 4'h0, 1, 2'b01, 1, 0, 2'b10, 0, 3'd3));
        re_cycles += int'(bus.MEM_RE);
        check_int("lw MEM_RE cycles", re_cycles, 4);
        tick();
        bus.MEM_ACK = 1'b0;
        #1 check("lw back to fetch", fetch_idle);

        // MEM_ACK held high through DECODE/EXECUTE must not skip the MEM phase
        bus.MEM_ACK = 1'b1;
        tick();
        bus.IR = 32'h00A52023;
        tick();
        #1 check("sw execute ack ignored", pk(0, 0, 2'b00, 3'd1, 0, 2'b01, 4'h0, 0, 2'b00, 0, 0, 2'b00, 0, 3'd2));
        tick();
        #1 check("sw mem ack", pk(0, 1, 2'b00, 3'd1, 0, 2'b01, 4'h0, 0, 2'b00, 0, 1, 2'b10, 0, 3'd3));
        tick();
        bus.MEM_ACK = 1'b0;

        // Reset in the middle of a load's MEM wait abandons it
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        bus.IR      = 32'h00052283;
        tick();
        tick();
        #1 check("mid-op in mem", pk(0, 0, 2'b00, 3'd0, 0, 2'b01, 4'h0, 0, 2'b00, 1, 0, 2'b10, 0, 3'd3));
        rst = 1'b1;
        #1 check("mid-op reset outputs", 25'd0);
        tick();
        rst = 1'b0;
        #1 check("mid-op after reset", fetch_idle);

`ifndef CTRL_TRAP_EN
        // Unbounded waits: no trap after well past the timeout length
        for (int i = 0; i < 20; i++) begin
            #1 check("long fetch wait", fetch_idle);
            tick();
        end
`else
        // Illegal opcode traps for exactly one cycle
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        bus.IR      = 32'hFFFFFFFF;
        tick();
        #1 check("illegal execute", pk(0, 0, 2'b00, 3'd0, 0, 2'b00, 4'h0, 0, 2'b00, 0, 0, 2'b00, 0, 3'd2));
        tick();
        #1 check("illegal trap", pk(0, 1, 2'b11, 3'd0, 0, 2'b00, 4'h0, 0, 2'b00, 0, 0, 2'b00, 1, 3'd4));
        tick();
        #1 check("after illegal trap", fetch_idle);

        // Fifteen ack-less fetch cycles time out
        for (int i = 0; i < 15; i++) begin
            #1 check("timeout wait", fetch_idle);
            tick();
        end
        #1 check("timeout trap", pk(0, 1, 2'b11, 3'd0, 0, 2'b00, 4'h0, 0, 2'b00, 0, 0, 2'b00, 1, 3'd4));
        tick();
        #1 check("after timeout trap", fetch_idle);

        // ACK on the fifteenth cycle wins over the timeout
        bus.IR = 32'h0000000F;
        for (int i = 0; i < 14; i++) tick();
        bus.MEM_ACK = 1'b1;
        #1 check("ack on cycle 15", fetch_ack);
        tick();
        bus.MEM_ACK = 1'b0;
        #1 check("decode after late ack", pk(0, 0, 2'b00, 3'd0, 0, 2'b00, 4'h0, 0, 2'b00, 0, 0, 2'b00, 0, 3'd1));
        tick();
        tick();
        #1 check("fetch after late ack", fetch_idle);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
